// File: rtl/whack_pkg.sv
// Shared definitions for the whack-a-mole display path: game states, screen size, colours.
package whack_pkg;

  typedef enum logic [2:0] {
    ST_START    = 3'd0,
    ST_GAME     = 3'd1,
    ST_MOLE1    = 3'd2,
    ST_MOLE2    = 3'd3,
    ST_MOLE3    = 3'd4,
    ST_MOLE4    = 3'd5,
    ST_GAMEOVER = 3'd6,
    ST_INVALID  = 3'd7
  } game_state_e;

  typedef enum logic [1:0] {
    DR_IDLE,
    DR_SWEEP,
    DR_FLUSH,
    DR_FIN
  } draw_state_e;

  localparam int H_RES_DEF = 160;
  localparam int V_RES_DEF = 120;
  localparam logic [2:0] BLACK = 3'b000;

  // An invalid game state has no image, so it is painted black.
  function automatic logic [2:0] plot_colour(input logic [2:0] sel, input logic [2:0] rom_q);
    return (sel == ST_INVALID) ? BLACK : rom_q;
  endfunction

endpackage

// File: rtl/pixel_delay_line.sv
// Valid-tagged shift register that carries pixel coordinates alongside the ROM read latency.
module pixel_delay_line #(
  parameter int LAT = 1,
  parameter int XW  = 8,
  parameter int YW  = 7
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          valid_i,
  input  logic [XW-1:0] x_i,
  input  logic [YW-1:0] y_i,
  output logic          valid_o,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o
);

  localparam int W = 1 + XW + YW;

  logic [W-1:0] stage_q [LAT];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < LAT; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= {valid_i, x_i, y_i};
      for (int i = 1; i < LAT; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign {valid_o, x_o, y_o} = stage_q[LAT-1];

endmodule

// File: rtl/frame_draw_ctrl.sv
// Full-screen redraw sequencer: sweeps every pixel once per game-state change and feeds the VGA adapter.
//   state    | meaning
//   DR_IDLE  | waiting for pending or a game-state change
//   DR_SWEEP | issuing one ROM address per cycle in raster order
//   DR_FLUSH | draining the delay line after the last address
//   DR_FIN   | frame complete, done pulse follows
module frame_draw_ctrl import whack_pkg::*; #(
  parameter int H_RES   = H_RES_DEF,
  parameter int V_RES   = V_RES_DEF,
  parameter int ROM_LAT = 1,
  parameter int ADDR_W  = 15
) (
  input  logic              iClock,
  input  logic              iResetn,
  input  logic [2:0]        iState,
  input  logic [2:0]        iRomQ,
  output logic [2:0]        oRomSel,
  output logic [ADDR_W-1:0] oRomAddr,
  output logic [7:0]        oX,
  output logic [6:0]        oY,
  output logic [2:0]        oColour,
  output logic              oPlot,
  output logic              oBusy,
  output logic              oDone
);

  localparam logic [7:0] X_LAST     = 8'(H_RES - 1);
  localparam logic [6:0] Y_LAST     = 7'(V_RES - 1);
  localparam logic [1:0] FLUSH_LOAD = 2'(ROM_LAT - 1);

  draw_state_e       state_q, state_d;
  logic [7:0]        cx_q, cx_d;
  logic [6:0]        cy_q, cy_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pending_q, pending_d;
  logic [2:0]        last_q, last_d;
  logic [2:0]        sel_q, sel_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [1:0]        flush_q, flush_d;

  logic              dl_valid;
  logic [7:0]        dl_x;
  logic [6:0]        dl_y;
  logic [7:0]        x_q;
  logic [6:0]        y_q;
  logic [2:0]        col_q;
  logic              plot_q;

  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      state_q   <= DR_IDLE;
      cx_q      <= '0;
      cy_q      <= '0;
      addr_q    <= '0;
      pending_q <= 1'b1;
      last_q    <= '0;
      sel_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      flush_q   <= '0;
    end else begin
      state_q   <= state_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      addr_q    <= addr_d;
      pending_q <= pending_d;
      last_q    <= last_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      flush_q   <= flush_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    addr_d    = addr_q;
    pending_d = pending_q;
    last_d    = last_q;
    sel_d     = sel_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    flush_d   = flush_q;
    // Any change during a frame (including FIN) is remembered; the frame itself is never aborted.
    if (iState != last_q) pending_d = 1'b1;
    case (state_q)
      DR_IDLE: begin
        if (pending_q || (iState != last_q)) begin
          last_d    = iState;
          sel_d     = iState;
          pending_d = 1'b0;
          cx_d      = '0;
          cy_d      = '0;
          addr_d    = '0;
          busy_d    = 1'b1;
          state_d   = DR_SWEEP;
        end
      end
      DR_SWEEP: begin
        if (cx_q == X_LAST) begin
          if (cy_q == Y_LAST) begin
            flush_d = FLUSH_LOAD;
            state_d = DR_FLUSH;
          end else begin
            cx_d   = '0;
            cy_d   = cy_q + 7'd1;
            addr_d = addr_q + ADDR_W'(1);
          end
        end else begin
          cx_d   = cx_q + 8'd1;
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      DR_FLUSH: begin
        if (flush_q == 2'd0) state_d = DR_FIN;
        else                 flush_d = flush_q - 2'd1;
      end
      DR_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = DR_IDLE;
      end
      default: state_d = DR_IDLE;
    endcase
  end

  pixel_delay_line #(
    .LAT (ROM_LAT),
    .XW  (8),
    .YW  (7)
  ) u_delay (
    .clk_i   (iClock),
    .rst_ni  (iResetn),
    .valid_i (state_q == DR_SWEEP),
    .x_i     (cx_q),
    .y_i     (cy_q),
    .valid_o (dl_valid),
    .x_o     (dl_x),
    .y_o     (dl_y)
  );

  // The delay line output and iRomQ refer to the same pixel, so one register stage keeps them aligned.
  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      x_q    <= '0;
      y_q    <= '0;
      col_q  <= BLACK;
      plot_q <= 1'b0;
    end else begin
      plot_q <= dl_valid;
      if (dl_valid) begin
        x_q   <= dl_x;
        y_q   <= dl_y;
        col_q <= plot_colour(sel_q, iRomQ);
      end
    end
  end

  assign oRomSel  = sel_q;
  assign oRomAddr = addr_q;
  assign oX       = x_q;
  assign oY       = y_q;
  assign oColour  = col_q;
  assign oPlot    = plot_q;
  assign oBusy    = busy_q;
  assign oDone    = done_q;

endmodule

// File: tb/tb_frame_draw_ctrl.sv
// Scoreboard bench for frame_draw_ctrl: a 1-cycle ROM build driven through several frames and a 2-cycle ROM build alongside.
module tb_frame_draw_ctrl;
  import whack_pkg::*;

  localparam int NPIX = 160 * 120;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  logic        iClock  = 1'b0;
  logic        iResetn = 1'b0;
  logic [2:0]  iState  = 3'd0;
  logic [2:0]  iRomQ   = 3'd0;
  logic [2:0]  oRomSel;
  logic [14:0] oRomAddr;
  logic [7:0]  oX;
  logic [6:0]  oY;
  logic [2:0]  oColour;
  logic        oPlot, oBusy, oDone;

  logic [2:0]  st2    = 3'd1;
  logic [2:0]  iRomQ2 = 3'd0;
  logic [2:0]  rom2_s1 = 3'd0;
  logic [2:0]  sel2;
  logic [14:0] addr2;
  logic [7:0]  x2;
  logic [6:0]  y2;
  logic [2:0]  col2;
  logic        plot2, busy2, done2;

  int checks = 0;
  int failures = 0;

  bit   rom_force7 = 1'b0;
  pix_t sb[$];
  int   runs[$];
  int   plot_cnt = 0, pix_err = 0, extra_plots = 0, run_len = 0;
  int   done_cnt = 0, done_long = 0, addr_over = 0;
  bit   prev_done = 1'b0, got_first = 1'b0;
  pix_t first_pix, last_pix, bad_obs, bad_exp;
  logic [2:0] c_159_0 = 3'bxxx, c_0_1 = 3'bxxx;
  int   cnt2 = 0, err2 = 0, idx2 = 0, done2_cnt = 0;

  frame_draw_ctrl #(.ROM_LAT(1)) u_dut (
    .iClock(iClock), .iResetn(iResetn), .iState(iState), .iRomQ(iRomQ),
    .oRomSel(oRomSel), .oRomAddr(oRomAddr), .oX(oX), .oY(oY), .oColour(oColour),
    .oPlot(oPlot), .oBusy(oBusy), .oDone(oDone)
  );

  frame_draw_ctrl #(.ROM_LAT(2)) u_dut2 (
    .iClock(iClock), .iResetn(iResetn), .iState(st2), .iRomQ(iRomQ2),
    .oRomSel(sel2), .oRomAddr(addr2), .oX(x2), .oY(y2), .oColour(col2),
    .oPlot(plot2), .oBusy(busy2), .oDone(done2)
  );

  always #5 iClock = ~iClock;

  // ROM models: the word is the low address bits, or all-ones when forced.
  always @(posedge iClock) iRomQ <= rom_force7 ? 3'b111 : oRomAddr[2:0];
  always @(posedge iClock) begin
    rom2_s1 <= addr2[2:0];
    iRomQ2  <= rom2_s1;
  end

  always @(negedge iClock) begin
    pix_t obs, exp_p;
    obs = {oX, oY, oColour};
    if (oPlot === 1'b1) begin
      plot_cnt++;
      run_len++;
      if (!got_first) begin got_first = 1'b1; first_pix = obs; end
      last_pix = obs;
      if (oX == 8'd159 && oY == 7'd0) c_159_0 = oColour;
      if (oX == 8'd0 && oY == 7'd1) c_0_1 = oColour;
      if (sb.size() == 0) extra_plots++;
      else begin
        exp_p = sb.pop_front();
        if (obs !== exp_p) begin
          if (pix_err == 0) begin bad_obs = obs; bad_exp = exp_p; end
          pix_err++;
        end
      end
    end else if (run_len != 0) begin
      runs.push_back(run_len);
      run_len = 0;
    end
    if (oDone === 1'b1) begin
      done_cnt++;
      if (prev_done) done_long++;
    end
    prev_done = (oDone === 1'b1);
    if (oRomAddr > 15'(NPIX - 1)) addr_over++;
  end

  always @(negedge iClock) begin
    if (plot2 === 1'b1) begin
      if ({x2, y2, col2} !== {8'(idx2 % 160), 7'(idx2 / 160), 3'(idx2)}) err2++;
      idx2++;
      cnt2++;
    end
    if (done2 === 1'b1) done2_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge iClock); #1; end
  endtask

  task automatic push_frame(input logic [2:0] sel);
    pix_t p;
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++) begin
        p.x = 8'(x);
        p.y = 7'(y);
        p.c = (sel == 3'd7) ? BLACK : (rom_force7 ? 3'd7 : 3'(y * 160 + x));
        sb.push_back(p);
      end
  endtask

  task automatic clear_monitors();
    sb.delete();
    runs.delete();
    plot_cnt = 0; pix_err = 0; extra_plots = 0; run_len = 0;
    done_cnt = 0; done_long = 0; addr_over = 0; got_first = 1'b0;
    c_159_0 = 3'bxxx; c_0_1 = 3'bxxx;
    cnt2 = 0; err2 = 0; idx2 = 0; done2_cnt = 0;
  endtask

  task automatic wait_plots(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30000; i++) begin
      if (plot_cnt >= target) begin ok = 1'b1; break; end
      tick(1);
    end
  endtask

  task automatic wait_done(output bit ok);
    int d0;
    d0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < 25000; i++) begin
      tick(1);
      if (done_cnt != d0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    iResetn = 1'b0;
    iState  = 3'd0;
    tick(3);
    checks++;
    if ({oRomSel, oRomAddr, oX, oY, oColour, oPlot, oBusy, oDone} !== 41'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0", {oRomSel, oRomAddr, oX, oY, oColour, oPlot, oBusy, oDone});
    end
    checks++;
    if ({plot2, busy2, done2, addr2} !== 18'd0) begin
      failures++;
      $display("FAIL reset_outputs_lat2 got=%h want=0", {plot2, busy2, done2, addr2});
    end
    clear_monitors();
    push_frame(3'd0);
    iResetn = 1'b1;
    checks++;
    if (oBusy !== 1'b0) begin failures++; $display("FAIL busy_before_edge got=%b want=0", oBusy); end
    tick(1);
    checks++;
    if ({oBusy, oRomSel} !== {1'b1, 3'd0}) begin
      failures++;
      $display("FAIL busy_after_release got=%b/%0d want=1/0", oBusy, oRomSel);
    end
  endtask

  task automatic test_first_pixels();
    bit ok;
    wait_plots(200, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL first_pixels_timeout got=%0d want>=200", plot_cnt); end
    checks++;
    if (!got_first || first_pix !== pix_t'(0)) begin
      failures++;
      $display("FAIL first_plot got=%h want=0", first_pix);
    end
    checks++;
    if (c_159_0 !== 3'd7) begin failures++; $display("FAIL colour_159_0 got=%b want=111", c_159_0); end
    checks++;
    if (c_0_1 !== 3'd0) begin failures++; $display("FAIL colour_0_1 got=%b want=000", c_0_1); end
    checks++;
    if (pix_err !== 0) begin
      failures++;
      $display("FAIL early_pixels errs=%0d got=%h want=%h", pix_err, bad_obs, bad_exp);
    end
  endtask

  task automatic test_reset_mid_and_invalid();
    bit ok;
    wait_plots(10000, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL reach_10000_timeout got=%0d want>=10000", plot_cnt); end
    iResetn = 1'b0;
    #1;
    checks++;
    if ({oPlot, oBusy, oRomAddr, oX, oY} !== 32'd0) begin
      failures++;
      $display("FAIL async_reset got=%h want=0", {oPlot, oBusy, oRomAddr, oX, oY});
    end
    tick(2);
    iState     = 3'd7;
    rom_force7 = 1'b1;
    clear_monitors();
    push_frame(3'd7);
    iResetn = 1'b1;
    tick(1);
    checks++;
    if ({oBusy, oRomSel} !== {1'b1, 3'd7}) begin
      failures++;
      $display("FAIL invalid_start got=%b/%0d want=1/7", oBusy, oRomSel);
    end
    wait_done(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL invalid_done_timeout got=%0d plots want=%0d", plot_cnt, NPIX); end
    checks++;
    if (pix_err !== 0 || plot_cnt !== NPIX || sb.size() !== 0) begin
      failures++;
      $display("FAIL invalid_frame errs=%0d plots=%0d left=%0d want=0/%0d/0 got=%h exp=%h",
               pix_err, plot_cnt, sb.size(), NPIX, bad_obs, bad_exp);
    end
    checks++;
    if (first_pix !== pix_t'(0) || last_pix !== {8'd159, 7'd119, 3'd0}) begin
      failures++;
      $display("FAIL invalid_ends got=%h/%h want=0/%h", first_pix, last_pix, {8'd159, 7'd119, 3'd0});
    end
    checks++;
    if (runs.size() !== 1 || runs[0] !== NPIX || done_long !== 0 || done_cnt !== 1) begin
      failures++;
      $display("FAIL invalid_contiguous runs=%0d first=%0d donelong=%0d dones=%0d want=1/%0d/0/1",
               runs.size(), (runs.size() > 0) ? runs[0] : -1, done_long, done_cnt, NPIX);
    end
    rom_force7 = 1'b0;
  endtask

  task automatic test_lat2();
    for (int i = 0; i < 20 && done2_cnt == 0; i++) tick(1);
    checks++;
    if (cnt2 !== NPIX || err2 !== 0 || done2_cnt !== 1) begin
      failures++;
      $display("FAIL lat2_frame plots=%0d errs=%0d dones=%0d want=%0d/0/1", cnt2, err2, done2_cnt, NPIX);
    end
  endtask

  task automatic test_idle_and_change();
    int p0;
    tick(4);
    p0 = plot_cnt;
    tick(2000);
    checks++;
    if (plot_cnt !== p0 || oBusy !== 1'b0) begin
      failures++;
      $display("FAIL idle_quiet plots=%0d busy=%b want=%0d/0", plot_cnt, oBusy, p0);
    end
    push_frame(3'd4);
    iState = 3'd4;
    tick(1);
    checks++;
    if ({oBusy, oRomSel} !== {1'b1, 3'd4}) begin
      failures++;
      $display("FAIL change_start got=%b/%0d want=1/4", oBusy, oRomSel);
    end
  endtask

  task automatic test_back_to_back();
    bit ok, bad_run;
    int base_p, base_d;
    base_p = plot_cnt;
    base_d = done_cnt;
    runs.delete();
    wait_plots(base_p + 500, ok);
    iState = 3'd2;
    wait_plots(base_p + 9000, ok);
    push_frame(3'd3);
    iState = 3'd3;
    tick(1);
    checks++;
    if (oRomSel !== 3'd4) begin failures++; $display("FAIL sel_held got=%0d want=4", oRomSel); end
    wait_done(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL frame4_done_timeout got=%0d plots", plot_cnt - base_p); end
    ok = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (oBusy === 1'b1) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || oRomSel !== 3'd3) begin
      failures++;
      $display("FAIL extra_frame_start busy=%b sel=%0d want=1/3", ok, oRomSel);
    end
    wait_done(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL frame3_done_timeout got=%0d plots", plot_cnt - base_p); end
    tick(500);
    checks++;
    if (plot_cnt - base_p !== 2 * NPIX || done_cnt - base_d !== 2) begin
      failures++;
      $display("FAIL back_to_back_totals plots=%0d dones=%0d want=%0d/2",
               plot_cnt - base_p, done_cnt - base_d, 2 * NPIX);
    end
    checks++;
    if (pix_err !== 0 || sb.size() !== 0 || extra_plots !== 0) begin
      failures++;
      $display("FAIL back_to_back_pixels errs=%0d left=%0d extra=%0d want=0/0/0 got=%h exp=%h",
               pix_err, sb.size(), extra_plots, bad_obs, bad_exp);
    end
    bad_run = (runs.size() != 2);
    foreach (runs[i]) if (runs[i] != NPIX) bad_run = 1'b1;
    checks++;
    if (bad_run || done_long !== 0 || addr_over !== 0 || last_pix !== {8'd159, 7'd119, 3'd7}) begin
      failures++;
      $display("FAIL back_to_back_shape runs=%0d donelong=%0d addrover=%0d last=%h want=2/0/0/%h",
               runs.size(), done_long, addr_over, last_pix, {8'd159, 7'd119, 3'd7});
    end
  endtask

  initial begin
    test_reset();
    test_first_pixels();
    test_reset_mid_and_invalid();
    test_lat2();
    test_idle_and_change();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
